// File: rtl/lavatory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lavatory_arbiter
// Brief    : Round-robin reservation arbiter sharing three lavatories between
//            women (lavs 0-2) and men (lavs 1-2), with door-sensor tracking.
// Revision : 1.0
// ============================================================================
module lavatory_arbiter #(
  parameter int QW          = 3,
  parameter int TMR_W       = 4,
  parameter int RES_TIMEOUT = 8
) (
  input  logic          clk_2,
  input  logic          reset,
  input  logic          req_w,
  input  logic          req_m,
  input  logic [2:0]    occ,
  output logic          grant_valid,
  output logic          grant_class,
  output logic [1:0]    grant_lav,
  output logic [2:0]    lav_busy,
  output logic          women_free,
  output logic          men_free,
  output logic [QW-1:0] q_w,
  output logic [QW-1:0] q_m,
  output logic          q_ovf
);

  typedef enum logic [1:0] {
    LAV_FREE     = 2'd0,
    LAV_RESERVED = 2'd1,
    LAV_OCCUPIED = 2'd2
  } lav_state_t;

  localparam logic [QW-1:0]    c_QMAX     = '1;
  localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(RES_TIMEOUT - 1);

  lav_state_t       r_state [3];
  lav_state_t       w_state_nxt [3];
  logic [TMR_W-1:0] r_tmr [3];
  logic [TMR_W-1:0] w_tmr_nxt [3];

  logic          r_req_w_prev, r_req_m_prev;
  logic [QW-1:0] r_q_w, r_q_m;
  logic          r_q_ovf;
  logic          r_gv, r_gc, r_last_class;
  logic [1:0]    r_gl;

  logic [2:0]    w_free, w_avail;
  logic          w_rise_w, w_rise_m;
  logic          w_cand_w_ok, w_cand_m_ok;
  logic [1:0]    w_cand_w, w_cand_m;
  logic          w_elig_w, w_elig_m;
  logic          w_grant_w, w_grant_m, w_grant;
  logic [1:0]    w_grant_lav;
  logic [QW:0]   w_qw_upd, w_qm_upd;

  // Returns {overflow, next count}; a simultaneous rise and grant cancel out.
  function automatic logic [QW:0] f_q_update(input logic [QW-1:0] q,
                                             input logic rise,
                                             input logic grant);
    logic [QW:0] res;
    res = {1'b0, q};
    case ({rise, grant})
      2'b10:   res = (q == c_QMAX) ? {1'b1, q} : {1'b0, q + 1'b1};
      2'b01:   res = {1'b0, q - 1'b1};
      default: res = {1'b0, q};
    endcase
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_free[i]  = (r_state[i] == LAV_FREE);
      w_avail[i] = w_free[i] & ~occ[i];
    end
  end

  assign w_rise_w    = req_w & ~r_req_w_prev;
  assign w_rise_m    = req_m & ~r_req_m_prev;

  assign w_cand_w_ok = |w_avail;
  assign w_cand_w    = w_avail[0] ? 2'd0 : (w_avail[1] ? 2'd1 : 2'd2);
  assign w_cand_m_ok = w_avail[1] | w_avail[2];
  assign w_cand_m    = w_avail[1] ? 2'd1 : 2'd2;

  assign w_elig_w    = (r_q_w != '0) & w_cand_w_ok;
  assign w_elig_m    = (r_q_m != '0) & w_cand_m_ok;

  // On contention the class that was not granted last wins.
  assign w_grant_w   = w_elig_w & (~w_elig_m | r_last_class);
  assign w_grant_m   = w_elig_m & ~w_grant_w;
  assign w_grant     = w_grant_w | w_grant_m;
  assign w_grant_lav = w_grant_w ? w_cand_w : w_cand_m;

  assign w_qw_upd    = f_q_update(r_q_w, w_rise_w, w_grant_w);
  assign w_qm_upd    = f_q_update(r_q_m, w_rise_m, w_grant_m);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_state_nxt[i] = r_state[i];
      w_tmr_nxt[i]   = r_tmr[i];
      case (r_state[i])
        LAV_FREE: begin
          if (w_grant && (w_grant_lav == 2'(i))) begin
            w_state_nxt[i] = LAV_RESERVED;
            w_tmr_nxt[i]   = '0;
          end else if (occ[i]) begin
            w_state_nxt[i] = LAV_OCCUPIED;
          end
        end
        LAV_RESERVED: begin
          if (occ[i]) begin
            w_state_nxt[i] = LAV_OCCUPIED;
            w_tmr_nxt[i]   = '0;
          end else if (r_tmr[i] == c_TMR_LAST) begin
            w_state_nxt[i] = LAV_FREE;
            w_tmr_nxt[i]   = '0;
          end else begin
            w_tmr_nxt[i]   = r_tmr[i] + 1'b1;
          end
        end
        LAV_OCCUPIED: begin
          if (!occ[i]) w_state_nxt[i] = LAV_FREE;
        end
        default: begin
          w_state_nxt[i] = LAV_FREE;
          w_tmr_nxt[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= LAV_FREE;
        r_tmr[i]   <= '0;
      end
      r_req_w_prev <= 1'b1;
      r_req_m_prev <= 1'b1;
      r_q_w        <= '0;
      r_q_m        <= '0;
      r_q_ovf      <= 1'b0;
      r_gv         <= 1'b0;
      r_gc         <= 1'b0;
      r_gl         <= 2'd0;
      r_last_class <= 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_tmr[i]   <= w_tmr_nxt[i];
      end
      r_req_w_prev <= req_w;
      r_req_m_prev <= req_m;
      r_q_w        <= w_qw_upd[QW-1:0];
      r_q_m        <= w_qm_upd[QW-1:0];
      r_q_ovf      <= r_q_ovf | w_qw_upd[QW] | w_qm_upd[QW];
      r_gv         <= w_grant;
      if (w_grant) begin
        r_gc         <= w_grant_m;
        r_gl         <= w_grant_lav;
        r_last_class <= w_grant_m;
      end
    end
  end

  assign grant_valid = r_gv;
  assign grant_class = r_gc;
  assign grant_lav   = r_gl;
  assign lav_busy    = ~w_free;
  assign women_free  = |w_free;
  assign men_free    = w_free[1] | w_free[2];
  assign q_w         = r_q_w;
  assign q_m         = r_q_m;
  assign q_ovf       = r_q_ovf;

endmodule
`default_nettype wire

// File: tb/tb_lavatory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lavatory_arbiter
// Brief    : Vector table, directed corner sequences and randomized run
//            against a behavioural model of the lavatory arbiter.
// Revision : 1.0
// ============================================================================
module tb_lavatory_arbiter;

  localparam int QW   = 3;
  localparam int RTO  = 8;
  localparam int QMAX = (1 << QW) - 1;

  logic          clk_2 = 1'b0;
  logic          reset = 1'b1;
  logic          req_w = 1'b0, req_m = 1'b0;
  logic [2:0]    occ = 3'b000;
  logic          grant_valid, grant_class, women_free, men_free, q_ovf;
  logic [1:0]    grant_lav;
  logic [2:0]    lav_busy;
  logic [QW-1:0] q_w, q_m;

  lavatory_arbiter #(.QW(QW), .TMR_W(4), .RES_TIMEOUT(RTO)) dut (
    .clk_2(clk_2), .reset(reset), .req_w(req_w), .req_m(req_m), .occ(occ),
    .grant_valid(grant_valid), .grant_class(grant_class), .grant_lav(grant_lav),
    .lav_busy(lav_busy), .women_free(women_free), .men_free(men_free),
    .q_w(q_w), .q_m(q_m), .q_ovf(q_ovf)
  );

  always #5 clk_2 = ~clk_2;

  int vecs = 0;
  int errs = 0;

  // Behavioural model: lavatory status 0=free 1=reserved 2=occupied.
  int m_st[3], m_tmr[3];
  int m_qw, m_qm, m_last, m_gc, m_gl;
  bit m_ovf, m_gv, m_pw, m_pm;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin m_st[i] = 0; m_tmr[i] = 0; end
    m_qw = 0; m_qm = 0; m_ovf = 0; m_gv = 0; m_gc = 0; m_gl = 0;
    m_last = 1; m_pw = 1; m_pm = 1;
  endtask

  task automatic model_step();
    int rw, rm, cw, cm, g, lav, n;
    rw = (req_w && !m_pw) ? 1 : 0;
    rm = (req_m && !m_pm) ? 1 : 0;
    cw = -1; cm = -1;
    for (int i = 0; i < 3; i++)
      if (m_st[i] == 0 && !occ[i]) begin
        if (cw < 0) cw = i;
        if (i > 0 && cm < 0) cm = i;
      end
    g = -1;
    if (m_qw > 0 && cw >= 0 && m_qm > 0 && cm >= 0) g = 1 - m_last;
    else if (m_qw > 0 && cw >= 0) g = 0;
    else if (m_qm > 0 && cm >= 0) g = 1;
    lav = (g == 0) ? cw : cm;
    for (int i = 0; i < 3; i++) begin
      if (g >= 0 && i == lav) begin m_st[i] = 1; m_tmr[i] = 0; end
      else if (m_st[i] == 0) begin if (occ[i]) m_st[i] = 2; end
      else if (m_st[i] == 1) begin
        if (occ[i]) m_st[i] = 2;
        else if (m_tmr[i] == RTO - 1) begin m_st[i] = 0; m_tmr[i] = 0; end
        else m_tmr[i]++;
      end else if (!occ[i]) m_st[i] = 0;
    end
    n = m_qw + rw - ((g == 0) ? 1 : 0);
    if (n > QMAX) begin n = QMAX; m_ovf = 1; end
    m_qw = n;
    n = m_qm + rm - ((g == 1) ? 1 : 0);
    if (n > QMAX) begin n = QMAX; m_ovf = 1; end
    m_qm = n;
    m_gv = (g >= 0);
    if (g >= 0) begin m_gc = g; m_gl = lav; m_last = g; end
    m_pw = req_w; m_pm = req_m;
  endtask

  function automatic logic [15:0] model_pack();
    logic [2:0] busy;
    for (int i = 0; i < 3; i++) busy[i] = (m_st[i] != 0);
    return {m_gv, m_gc[0], m_gl[1:0], busy, ~&busy, ~(busy[1] & busy[2]),
            m_qw[QW-1:0], m_qm[QW-1:0], m_ovf};
  endfunction

  function automatic logic [15:0] dut_pack();
    return {grant_valid, grant_class, grant_lav, lav_busy, women_free, men_free,
            q_w, q_m, q_ovf};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    model_step();
    #1;
  endtask

  // Asynchronous reset; outputs must reach reset values without a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    chk("reset_vals", dut_pack(), {1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0});
    repeat (2) @(posedge clk_2);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic          rst_before;
    logic          rw, rm;
    logic [2:0]    occ;
    logic          gv, gc;
    logic [1:0]    gl;
    logic [2:0]    busy;
    logic [QW-1:0] qw, qm;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic rb, input logic rw, input logic rm,
                              input logic [2:0] oc, input logic gv, input logic gc,
                              input logic [1:0] gl, input logic [2:0] busy,
                              input int qw, input int qm);
    vec_t v;
    v.rst_before = rb; v.rw = rw; v.rm = rm; v.occ = oc; v.gv = gv; v.gc = gc;
    v.gl = gl; v.busy = busy; v.qw = QW'(qw); v.qm = QW'(qm);
    tbl.push_back(v);
  endfunction

  initial begin
    // Single women request, full 8-cycle reservation expiry.
    add(1, 0, 0, 3'b000, 0, 0, 2'd0, 3'b000, 0, 0);
    add(0, 1, 0, 3'b000, 0, 0, 2'd0, 3'b000, 1, 0);
    add(0, 1, 0, 3'b000, 1, 0, 2'd0, 3'b001, 0, 0);
    for (int k = 0; k < 7; k++) add(0, 0, 0, 3'b000, 0, 0, 2'd0, 3'b001, 0, 0);
    add(0, 0, 0, 3'b000, 0, 0, 2'd0, 3'b000, 0, 0);
    // Reservation turned into occupancy on the fifth cycle, then vacated.
    add(0, 1, 0, 3'b000, 0, 0, 2'd0, 3'b000, 1, 0);
    add(0, 0, 0, 3'b000, 1, 0, 2'd0, 3'b001, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 3'b000, 0, 0, 2'd0, 3'b001, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 3'b001, 0, 0, 2'd0, 3'b001, 0, 0);
    add(0, 0, 0, 3'b000, 0, 0, 2'd0, 3'b000, 0, 0);
    // Two requests per class queued while all occupied, then alternating grants.
    add(1, 0, 0, 3'b111, 0, 0, 2'd0, 3'b111, 0, 0);
    add(0, 1, 1, 3'b111, 0, 0, 2'd0, 3'b111, 1, 1);
    add(0, 0, 0, 3'b111, 0, 0, 2'd0, 3'b111, 1, 1);
    add(0, 1, 1, 3'b111, 0, 0, 2'd0, 3'b111, 2, 2);
    add(0, 0, 0, 3'b000, 0, 0, 2'd0, 3'b000, 2, 2);
    add(0, 0, 0, 3'b000, 1, 0, 2'd0, 3'b001, 1, 2);
    add(0, 0, 0, 3'b000, 1, 1, 2'd1, 3'b011, 1, 1);
    add(0, 0, 0, 3'b000, 1, 0, 2'd2, 3'b111, 0, 1);
    add(0, 0, 0, 3'b000, 0, 0, 2'd2, 3'b111, 0, 1);

    model_reset();
    foreach (tbl[i]) begin
      if (tbl[i].rst_before) begin
        req_w = 0; req_m = 0; occ = 3'b000;
        do_reset();
      end
      req_w = tbl[i].rw; req_m = tbl[i].rm; occ = tbl[i].occ;
      tick();
      chk($sformatf("tbl[%0d]", i),
          {grant_valid, grant_class, grant_lav, lav_busy, q_w, q_m, q_ovf},
          {tbl[i].gv, tbl[i].gc, tbl[i].gl, tbl[i].busy, tbl[i].qw, tbl[i].qm, 1'b0});
    end

    // Men blocked by occupied lavs 1 and 2 until lav 1 is vacated.
    req_w = 0; req_m = 0; occ = 3'b000;
    do_reset();
    occ = 3'b110; tick();
    chk("men_blk_free", {12'd0, lav_busy, women_free, men_free}, {12'd0, 3'b110, 1'b1, 1'b0});
    req_m = 1; tick();
    chk("men_blk_q", {14'd0, grant_valid, 1'b0} | 16'(q_m), {14'd0, 1'b0, 1'b0} | 16'd1);
    tick();
    chk("men_blk_hold", {12'd0, grant_valid, men_free, q_m[1:0]}, {12'd0, 1'b0, 1'b0, 2'd1});
    occ = 3'b100; tick();
    chk("men_lav1_freed", {10'd0, grant_valid, lav_busy, men_free, q_m[0]}, {10'd0, 1'b0, 3'b100, 1'b1, 1'b1});
    tick();
    chk("men_grant_lav1", {8'd0, grant_valid, grant_class, grant_lav, lav_busy, q_m[0]},
        {8'd0, 1'b1, 1'b1, 2'd1, 3'b110, 1'b0});

    // Saturation: coincident rise+grant at max must not flag overflow.
    req_w = 0; req_m = 0; occ = 3'b000;
    do_reset();
    occ = 3'b111; tick();
    for (int k = 0; k < QMAX; k++) begin
      req_m = 1; tick();
      req_m = 0; tick();
    end
    chk("sat_fill", {12'd0, q_m, q_ovf}, {12'd0, 3'd7, 1'b0});
    occ = 3'b000; tick();
    req_m = 1; tick();
    chk("sat_rise_grant", {8'd0, grant_valid, grant_class, grant_lav, q_m, q_ovf},
        {8'd0, 1'b1, 1'b1, 2'd1, 3'd7, 1'b0});
    occ = 3'b111; req_m = 0; tick();
    req_m = 1; tick();
    chk("sat_ovf", {11'd0, grant_valid, q_m, q_ovf}, {11'd0, 1'b0, 3'd7, 1'b1});

    // Reset with a reservation and queued request, women request held high.
    req_w = 0; req_m = 0; occ = 3'b000;
    do_reset();
    tick();
    req_w = 1; req_m = 1; tick();
    tick();
    chk("pre_rst", {9'd0, lav_busy, q_w[0], q_m}, {9'd0, 3'b001, 1'b0, 3'd1});
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("held_req_ignored", {14'd0, grant_valid, |q_w}, 16'd0);
    end
    req_w = 0; req_m = 0; tick();
    req_w = 1; tick();
    chk("req_after_toggle", {13'd0, q_w}, {13'd0, 3'd1});

    // Randomized run against the model.
    req_w = 0; req_m = 0; occ = 3'b000;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) == 0) req_w = ~req_w;
      if ($urandom_range(0, 2) == 0) req_m = ~req_m;
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 6) == 0) occ[b] = ~occ[b];
      if ($urandom_range(0, 299) == 0) do_reset();
      tick();
      chk("rand", dut_pack(), model_pack());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lavatory_arbiter.md
Name: lavatory_arbiter

Overview:
- Sequential arbiter sharing three aircraft lavatories between two requester classes: women (class 0) and men (class 1).
- Women may use lavatories 0, 1 and 2. Men may use only lavatories 1 and 2.
- Counts pending requests per class, issues one reservation grant per cycle with round-robin fairness, and tracks each lavatory through FREE/RESERVED/OCCUPIED states using door sensors.
- Instantiated under top; driven by SWI bits, with status shown on LED/SEG.

Parameters:
QW, 3, width of each class queue counter (saturates at 2**QW-1)
TMR_W, 4, width of per-lavatory reservation timer
RES_TIMEOUT, 8, cycles a RESERVED lavatory waits for occupancy before returning to FREE (1 <= RES_TIMEOUT < 2**TMR_W)

Ports:
clk_2  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req_w  input  1  women request level; each rising edge is one request
req_m  input  1  men request level; each rising edge is one request
occ  input  3  door-locked sensor per lavatory, 1 = occupied
grant_valid  output  1  one-cycle pulse: a reservation was made
grant_class  output  1  class of last grant (0 = women, 1 = men)
grant_lav  output  2  lavatory index of last grant (0..2)
lav_busy  output  3  per lavatory, 1 when state is not FREE
women_free  output  1  any lavatory FREE
men_free  output  1  lavatory 1 or 2 FREE
q_w  output  QW  pending women requests
q_m  output  QW  pending men requests
q_ovf  output  1  sticky: a request was dropped at saturation

Behaviour:
- Reset values (asynchronous):
  - all lavatories FREE, all timers 0
  - q_w = q_m = 0, q_ovf = 0
  - grant_valid = 0, grant_class = 0, grant_lav = 0
  - round-robin pointer set so women have priority on the first contention
  - req_w_prev = req_m_prev = 1, so requests held high through reset are not counted
- Outputs are registered, except women_free, men_free and lav_busy, which decode the registered state.
- Edge detect:
  - rise_x = req_x & ~req_x_prev, with the previous value registered every cycle.
  - A rise sampled at edge k makes q_x increment visible after edge k.
- Queue update per class, evaluated per edge:
  - rise only: q + 1.
  - grant only: q - 1.
  - rise and grant together: q unchanged.
  - rise at q = max with no grant: q stays at max and q_ovf sets; q_ovf clears only on reset.
- Lavatory FSM, per lavatory i:
  - FREE -> RESERVED on a grant to i; the timer loads 0.
  - FREE -> OCCUPIED if occ[i] = 1 (entry without grant); no grant is issued to i in that cycle.
  - RESERVED -> OCCUPIED when occ[i] = 1. occ has priority over timeout.
  - RESERVED with occ[i] = 0: the timer increments. When timer == RES_TIMEOUT-1 the lavatory returns to FREE, so RESERVED lasts exactly RES_TIMEOUT cycles.
  - OCCUPIED -> FREE when occ[i] = 0.
- Arbitration, combinational from registered state; the result is registered at the same edge:
  - Women candidate: lowest-index FREE lavatory among {0,1,2} with occ = 0.
  - Men candidate: lowest-index FREE lavatory among {1,2} with occ = 0.
  - A class is eligible when q > 0 and it has a candidate.
  - If only one class is eligible, grant it.
  - If both are eligible, grant the class not granted last (round-robin), then update the pointer.
  - At most one grant per cycle.
  - On a grant: grant_valid = 1 for exactly one cycle, grant_class and grant_lav are loaded, the chosen lavatory goes to RESERVED, and q decrements.
  - With no grant: grant_valid = 0, and grant_class and grant_lav hold their values.
- Latency: a request rise sampled at edge k, with an eligible lavatory, produces grant_valid high after edge k+1.
- Men are never granted lavatory 0. Requests with no candidate stay queued indefinitely.
- Reset mid-operation discards all reservations and queued requests immediately.

Test Plan:
- Reset, then one req_w rise with all lavatories free -> q_w = 1 after 1 edge; next edge grant_valid = 1, class 0, lav 0, lav_busy = 001, q_w = 0.
- Occ stays 0 after the grant -> lavatory 0 RESERVED for exactly 8 cycles, then lav_busy = 000. If occ[0] rises at cycle 5 -> OCCUPIED; clearing occ[0] -> FREE the next edge.
- Both queues = 2, all lavatories free, no occ -> grants alternate: W-lav0, M-lav1, W-lav2; then men are stalled with q_m = 1 until lav1 or lav2 frees.
- occ = 110 (lav1 and lav2 occupied), req_m rise -> men_free = 0, no grant, q_m = 1; clear occ[1] -> the next edge grants M-lav1.
- 8 req_m rises with no free lavatory, QW = 3 -> q_m = 7 and q_ovf = 1. A rise coinciding with a grant when q = 7 -> q stays 7 and q_ovf is not set by that event.
- Assert reset while lavatories are RESERVED and queues are nonzero, with req_w held high -> all outputs return to reset values; after release no request is counted until req_w toggles 0 -> 1.
